// File: rtl/dtw_ref_streamer_pkg.sv
// Shared types for the reference streamer: FSM encoding, per-pair tag layout, read timing.
// Tag travels with each read so the pair leaves the buffer already labelled {odd, last, pass}.
package dtw_ref_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Control half of the tag; the pass index follows it as {odd, last, pass}.
    typedef struct packed {
        logic odd;
        logic last;
    } tag_ctrl_t;

    localparam int TAG_CTRL_W = $bits(tag_ctrl_t);
    localparam int RD_LAT     = 1;
    localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/dtw_ref_streamer_if.sv
// Reference pair stream towards the DTW compute array.
// Valid/ready: a pair transfers on m_valid_out & m_ready_in, and holds steady while stalled.
interface dtw_ref_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PASS_WIDTH = 16
);
    logic                  m_valid_out;
    logic                  m_ready_in;
    logic [DATA_WIDTH-1:0] m_data_0_out;
    logic [DATA_WIDTH-1:0] m_data_1_out;
    logic                  m_odd_out;
    logic                  m_last_out;
    logic [PASS_WIDTH-1:0] m_pass_out;

    modport master (
        output m_valid_out, m_data_0_out, m_data_1_out, m_odd_out, m_last_out, m_pass_out,
        input  m_ready_in
    );

    modport slave (
        input  m_valid_out, m_data_0_out, m_data_1_out, m_odd_out, m_last_out, m_pass_out,
        output m_ready_in
    );
endinterface

// File: rtl/dtw_ref_skid_buf.sv
// Two-entry FIFO absorbing read data in flight; head visible the cycle after push.
// Push/pop in the same cycle are allowed; flush empties it and wins over push/pop.
module dtw_ref_skid_buf
    import dtw_ref_streamer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/dtw_ref_streamer.sv
// Replays the reference memory as (2k, 2k+1) sample pairs, once per pass, for num_passes passes.
// First pair 2 cycles after start; 1 pair/cycle; reads are only issued when the skid buffer has room.
module dtw_ref_streamer
    import dtw_ref_streamer_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int PASS_WIDTH       = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic                        ref_load_done_in,
    input  logic [REFMEM_PTR_WIDTH-1:0] ref_len_in,
    input  logic [PASS_WIDTH-1:0]       num_passes_in,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_0_out,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_1_out,
    input  logic [DATA_WIDTH-1:0]       ref_data_0_in,
    input  logic [DATA_WIDTH-1:0]       ref_data_1_in,
    dtw_ref_streamer_if.master          m,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        err_out,
    output logic [1:0]                  dbg_state
);
    localparam int TAG_W = TAG_CTRL_W + PASS_WIDTH;
    localparam int BUF_W = TAG_W + 2 * DATA_WIDTH;
    localparam int LVL_W = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

    state_t                      state;
    logic [REFMEM_PTR_WIDTH-1:0] len_q, a0_q, addr0_q, addr1_q, a1;
    logic [PASS_WIDTH-1:0]       npass_q, pass_q, infl_pass;
    tag_ctrl_t                   infl_ctrl, head_ctrl;
    logic                        infl_q, err_q, done_q;
    logic                        cur_last, cur_odd, issue, pop;
    logic [1:0]                  occ;
    logic [LVL_W-1:0]            lvl, room;
    logic [DATA_WIDTH-1:0]       d1_cap;
    logic [BUF_W-1:0]            push_dat, head_dat;

    assign a1       = a0_q + REFMEM_PTR_WIDTH'(1);
    assign cur_last = (a0_q + REFMEM_PTR_WIDTH'(2)) >= len_q;
    assign cur_odd  = (a1 == len_q);

    // Room check counts the pair already in flight and the slot freed by this cycle's pop.
    assign pop   = m.m_valid_out & m.m_ready_in;
    assign lvl   = LVL_W'(occ) + LVL_W'(infl_q);
    assign room  = LVL_W'(BUF_DEPTH) + LVL_W'(pop);
    assign issue = (state == ST_ISSUE) && !abort_in && (lvl < room);

    assign ref_addr_0_out = issue ? a0_q : addr0_q;
    assign ref_addr_1_out = issue ? a1   : addr1_q;

    // Odd final pair reads address len on port 1; that word is not part of the reference.
    assign d1_cap   = infl_ctrl.odd ? '0 : ref_data_1_in;
    assign push_dat = {infl_ctrl, infl_pass, d1_cap, ref_data_0_in};

    dtw_ref_skid_buf #(.W(BUF_W)) u_skid (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (abort_in),
        .push     (infl_q),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .occ      (occ)
    );

    assign {head_ctrl, m.m_pass_out, m.m_data_1_out, m.m_data_0_out} = head_dat;
    assign m.m_odd_out   = head_ctrl.odd;
    assign m.m_last_out  = head_ctrl.last;
    assign m.m_valid_out = (occ != 2'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            npass_q   <= '0;
            a0_q      <= '0;
            pass_q    <= '0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            infl_q    <= 1'b0;
            infl_ctrl <= '0;
            infl_pass <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            infl_q <= issue;
            if (issue) begin
                infl_ctrl <= '{odd: cur_odd, last: cur_last};
                infl_pass <= pass_q;
                addr0_q   <= a0_q;
                addr1_q   <= a1;
            end
            if (abort_in) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_in) begin
                            if (ref_load_done_in && ref_len_in != '0 && num_passes_in != '0) begin
                                len_q   <= ref_len_in;
                                npass_q <= num_passes_in;
                                a0_q    <= '0;
                                pass_q  <= '0;
                                err_q   <= 1'b0;
                                state   <= ST_ISSUE;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (issue) begin
                            if (!cur_last) begin
                                a0_q <= a0_q + REFMEM_PTR_WIDTH'(2);
                            end else if (pass_q < npass_q - PASS_WIDTH'(1)) begin
                                a0_q   <= '0;
                                pass_q <= pass_q + PASS_WIDTH'(1);
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Leave as the buffer empties, so done lands the cycle after the last accept.
                        if (!infl_q && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_out  = (state != ST_IDLE);
    assign done_out  = done_q;
    assign err_out   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// Scoreboard bench for dtw_ref_streamer: directed runs push expected pairs, a monitor pops and compares.
module tb_dtw_ref_streamer;

    logic        clk_in = 1'b0;
    logic        rst_in, start_in, abort_in, ref_load_done_in;
    logic [19:0] ref_len_in;
    logic [15:0] num_passes_in;
    logic [19:0] ref_addr_0_out, ref_addr_1_out;
    logic [15:0] ref_data_0_in = '0;
    logic [15:0] ref_data_1_in = '0;
    logic        busy_out, done_out, err_out;
    logic [1:0]  dbg_state;

    always #5 clk_in = ~clk_in;

    dtw_ref_streamer_if #(.DATA_WIDTH(16), .PASS_WIDTH(16)) m_if ();

    dtw_ref_streamer #(.DATA_WIDTH(16), .REFMEM_PTR_WIDTH(20), .PASS_WIDTH(16)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .ref_load_done_in (ref_load_done_in),
        .ref_len_in       (ref_len_in),
        .num_passes_in    (num_passes_in),
        .ref_addr_0_out   (ref_addr_0_out),
        .ref_addr_1_out   (ref_addr_1_out),
        .ref_data_0_in    (ref_data_0_in),
        .ref_data_1_in    (ref_data_1_in),
        .m                (m_if),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .err_out          (err_out),
        .dbg_state        (dbg_state)
    );

    // Synchronous reference memory, mem[i] = i + 0x100.
    always @(posedge clk_in) begin
        ref_data_0_in <= ref_addr_0_out[15:0] + 16'h0100;
        ref_data_1_in <= ref_addr_1_out[15:0] + 16'h0100;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [49:0] sb_q[$];
    int          done_cnt = 0, done_cyc = 0, first_acc = -1, last_acc = -1;
    logic        prev_stall = 1'b0;
    logic [49:0] prev_vec = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    always @(negedge clk_in) begin
        logic [49:0] cur, e;
        cur = {m_if.m_data_0_out, m_if.m_data_1_out, m_if.m_odd_out, m_if.m_last_out, m_if.m_pass_out};
        if (!rst_in || abort_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", 64'({m_if.m_valid_out, cur}), 64'({1'b1, prev_vec}));
            if (m_if.m_valid_out) check("busy_while_valid", 64'(busy_out), 64'd1);
            if (m_if.m_valid_out && m_if.m_ready_in) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pair: got %0h, want no pair", cur);
                end else begin
                    e = sb_q.pop_front();
                    check("pair", 64'(cur), 64'(e));
                end
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            prev_stall = m_if.m_valid_out & ~m_if.m_ready_in;
            prev_vec   = cur;
        end
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic new_test();
        done_cnt  = 0;
        first_acc = -1;
        last_acc  = -1;
    endtask

    task automatic expect_run(input int len, input int passes);
        int npairs;
        npairs = (len + 1) / 2;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < npairs; k++) begin
                logic [15:0] d0, d1;
                logic        odd, last;
                d0   = 16'(2 * k + 256);
                odd  = (2 * k + 1 == len);
                d1   = odd ? 16'h0000 : 16'(2 * k + 1 + 256);
                last = (k == npairs - 1);
                sb_q.push_back({d0, d1, odd, last, 16'(p)});
            end
        end
    endtask

    task automatic do_start(input int len, input int passes, input logic ld, output int s_cyc);
        ref_len_in       = 20'(len);
        num_passes_in    = 16'(passes);
        ref_load_done_in = ld;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        s_cyc    = cyc;
    endtask

    task automatic wait_done(input int n, input string tag);
        int t;
        t = 0;
        while (done_cnt < n && t < 400) begin
            tick();
            t++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt >= n), 64'd1);
        repeat (3) tick();
        check({tag, "_done_once"}, 64'(done_cnt), 64'(n));
        check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        check({tag, "_idle"}, 64'({busy_out, dbg_state}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        rst_in = 1'b0; start_in = 1'b0; abort_in = 1'b0; ref_load_done_in = 1'b0;
        ref_len_in = '0; num_passes_in = '0; m_if.m_ready_in = 1'b0;
        repeat (3) tick();
        check("rst_addr", 64'({ref_addr_0_out, ref_addr_1_out}), 64'd0);
        check("rst_stream", 64'({m_if.m_valid_out, m_if.m_data_0_out, m_if.m_data_1_out,
                                 m_if.m_odd_out, m_if.m_last_out, m_if.m_pass_out}), 64'd0);
        check("rst_status", 64'({busy_out, done_out, err_out, dbg_state}), 64'd0);
        rst_in = 1'b1;
        tick();

        // len=6, one pass, ready high: three back-to-back pairs
        m_if.m_ready_in = 1'b1;
        new_test(); expect_run(6, 1); do_start(6, 1, 1'b1, s);
        wait_done(1, "t1");
        check("t1_first_latency", 64'(first_acc - s), 64'd2);
        check("t1_stream", 64'(last_acc - first_acc), 64'd2);
        check("t1_done_timing", 64'(done_cyc - last_acc), 64'd1);

        // len=5, two passes: odd last pair each pass, no bubble at the pass boundary
        new_test(); expect_run(5, 2); do_start(5, 2, 1'b1, s);
        wait_done(1, "t2");
        check("t2_stream", 64'(last_acc - first_acc), 64'd5);
        check("t2_done_timing", 64'(done_cyc - last_acc), 64'd1);

        // len=8 with random backpressure
        new_test(); expect_run(8, 1); do_start(8, 1, 1'b1, s);
        for (int t = 0; t < 400 && done_cnt < 1; t++) begin
            m_if.m_ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        m_if.m_ready_in = 1'b1;
        wait_done(1, "t3");
        check("t3_done_timing", 64'(done_cyc - last_acc), 64'd1);

        // Illegal starts set err and stay idle; a legal start clears err
        new_test();
        do_start(4, 1, 1'b0, s);
        check("t4_no_load", 64'({err_out, busy_out, dbg_state}), 64'b1000);
        do_start(0, 1, 1'b1, s);
        check("t4_len_zero", 64'({err_out, busy_out, dbg_state}), 64'b1000);
        do_start(4, 0, 1'b1, s);
        check("t4_pass_zero", 64'({err_out, busy_out, dbg_state}), 64'b1000);
        repeat (2) tick();
        check("t4_no_done", 64'(done_cnt), 64'd0);
        expect_run(2, 1); do_start(2, 1, 1'b1, s);
        check("t4_err_clear", 64'({err_out, dbg_state}), 64'b001);
        wait_done(1, "t4");

        // Abort with the buffer full under backpressure, then replay from address 0
        m_if.m_ready_in = 1'b0;
        new_test(); do_start(8, 1, 1'b1, s);
        repeat (6) tick();
        check("t5_full_valid", 64'(m_if.m_valid_out), 64'd1);
        check("t5_addr_hold", 64'({ref_addr_0_out, ref_addr_1_out}), 64'({20'd2, 20'd3}));
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("t5_abort", 64'({m_if.m_valid_out, busy_out, dbg_state}), 64'd0);
        repeat (4) tick();
        check("t5_no_done", 64'(done_cnt), 64'd0);
        check("t5_err_kept", 64'(err_out), 64'd0);
        m_if.m_ready_in = 1'b1;
        new_test(); expect_run(4, 1); do_start(4, 1, 1'b1, s);
        wait_done(1, "t5r");
        check("t5r_first_latency", 64'(first_acc - s), 64'd2);

        // Asynchronous reset in the middle of a run
        new_test(); expect_run(8, 3); do_start(8, 3, 1'b1, s);
        repeat (3) tick();
        #1 rst_in = 1'b0;
        #1;
        check("t6_rst_addr", 64'({ref_addr_0_out, ref_addr_1_out}), 64'd0);
        check("t6_rst_stream", 64'({m_if.m_valid_out, m_if.m_data_0_out, m_if.m_data_1_out,
                                    m_if.m_odd_out, m_if.m_last_out, m_if.m_pass_out}), 64'd0);
        check("t6_rst_status", 64'({busy_out, done_out, err_out, dbg_state}), 64'd0);
        sb_q.delete();
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        check("t6_idle_after", 64'({busy_out, dbg_state}), 64'd0);
        new_test(); expect_run(3, 1); do_start(3, 1, 1'b1, s);
        wait_done(1, "t6r");
        check("t6r_first_latency", 64'(first_acc - s), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
